// File: rtl/n_bit_adder_pipe.sv
// Pipelined two's-complement adder: the carry chain is cut into STAGES equal chunks, one per register stage.
// Optional ADDER_SATURATE_EN clamps the result on signed overflow in the final stage.
module n_bit_adder_pipe #(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic             carry_in,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             carry_out,
   output logic             overflow
);

   localparam int CHUNK = (STAGES > 0) ? WIDTH / STAGES : WIDTH;

   if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
      $error("n_bit_adder_pipe: illegal WIDTH/STAGES combination");
   end

   // Stage k sources: operands still carrying unconsumed chunks, incoming carry and low result chunks.
   logic [WIDTH-1:0] a_s   [STAGES];
   logic [WIDTH-1:0] b_s   [STAGES];
   logic [WIDTH-1:0] lo_s  [STAGES];
   logic             c_s   [STAGES];
   logic             v_s   [STAGES];

   logic [WIDTH-1:0] a_d     [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_d     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] sum_d   [STAGES];
   logic [WIDTH-1:0] sum_q   [STAGES];
   logic             carry_d [STAGES];
   logic             carry_q [STAGES];
   logic             valid_d [STAGES];
   logic             valid_q [STAGES];

   logic [WIDTH-1:0] raw_sum;
   logic             ovf_d;
   logic             ovf_q;

   always_comb begin
      logic [CHUNK:0]   part;
      logic [WIDTH-1:0] keep;
      part = '0;
      keep = '0;

      a_s[0]  = input1;
      b_s[0]  = input2;
      c_s[0]  = carry_in;
      v_s[0]  = in_valid;
      lo_s[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         a_s[k]  = a_q[k-1];
         b_s[k]  = b_q[k-1];
         c_s[k]  = carry_q[k-1];
         v_s[k]  = valid_q[k-1];
         lo_s[k] = sum_q[k-1];
      end

      for (int k = 0; k < STAGES; k++) begin
         part = {1'b0, a_s[k][k*CHUNK +: CHUNK]}
              + {1'b0, b_s[k][k*CHUNK +: CHUNK]}
              + (CHUNK+1)'(c_s[k]);
         // Drop chunks consumed up to and including this stage; the last stage keeps nothing.
         keep       = ~((WIDTH'(1) << ((k+1)*CHUNK)) - WIDTH'(1));
         a_d[k]     = a_s[k] & keep;
         b_d[k]     = b_s[k] & keep;
         sum_d[k]   = lo_s[k] | (WIDTH'(part[CHUNK-1:0]) << (k*CHUNK));
         carry_d[k] = part[CHUNK];
         valid_d[k] = v_s[k];
      end

      raw_sum = sum_d[STAGES-1];
      ovf_d   = (a_s[STAGES-1][WIDTH-1] == b_s[STAGES-1][WIDTH-1])
             && (raw_sum[WIDTH-1] != a_s[STAGES-1][WIDTH-1]);
`ifdef ADDER_SATURATE_EN
      if (ovf_d)
         sum_d[STAGES-1] = a_s[STAGES-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                  : {1'b0, {(WIDTH-1){1'b1}}};
      else
         sum_d[STAGES-1] = raw_sum;
`else
      sum_d[STAGES-1] = raw_sum;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            valid_q[k] <= 1'b0;
         end
         ovf_q <= 1'b0;
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            valid_q[k] <= valid_d[k];
         end
         ovf_q <= ovf_d;
      end
   end

   assign out       = sum_q[STAGES-1];
   assign carry_out = carry_q[STAGES-1];
   assign overflow  = ovf_q;
   assign out_valid = valid_q[STAGES-1];

endmodule

// File: tb/tb_n_bit_adder_pipe.sv
// Self-checking bench for n_bit_adder_pipe (WIDTH=16, STAGES=2): directed corner sums plus random
// streams checked against a plain-arithmetic reference and a queue that models the fixed latency.
module tb_n_bit_adder_pipe;
   localparam int WIDTH  = 16;
   localparam int STAGES = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              in_valid = 1'b0;
   logic              carry_in = 1'b0;
   logic [WIDTH-1:0]  input1 = '0;
   logic [WIDTH-1:0]  input2 = '0;
   logic [WIDTH-1:0]  out;
   logic              out_valid;
   logic              carry_out;
   logic              overflow;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic        v;
      logic [15:0] a;
      logic [15:0] b;
      logic        c;
   } txn_t;

   txn_t pipe_q[$];
   logic [15:0] corner [4];

   always #5 clk = ~clk;

   n_bit_adder_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .input1    (input1),
      .input2    (input2),
      .carry_in  (carry_in),
      .out       (out),
      .out_valid (out_valid),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   function automatic void ref_add(input logic [15:0] a, input logic [15:0] b, input logic c,
                                   output logic [15:0] o, output logic co, output logic ov);
      logic [16:0] s;
      s  = 17'(a) + 17'(b) + 17'(c);
      o  = s[15:0];
      co = s[16];
      ov = (a[15] == b[15]) && (s[15] != a[15]);
`ifdef ADDER_SATURATE_EN
      if (ov) o = a[15] ? 16'h8000 : 16'h7FFF;
`endif
   endfunction

   function automatic logic [15:0] rand_operand();
      if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
      return 16'($urandom);
   endfunction

   // Drive one cycle, advance past the edge, and return what the output should show now.
   task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic c,
                       output logic ev, output logic [15:0] eo, output logic ec, output logic eov);
      txn_t t;
      txn_t e;
      in_valid = v;
      input1   = a;
      input2   = b;
      carry_in = c;
      @(posedge clk);
      #1;
      t.v = v; t.a = a; t.b = b; t.c = c;
      pipe_q.push_back(t);
      ev = 1'b0; eo = '0; ec = 1'b0; eov = 1'b0;
      if (pipe_q.size() > STAGES - 1) begin
         e  = pipe_q.pop_front();
         ev = e.v;
         ref_add(e.a, e.b, e.c, eo, ec, eov);
      end
   endtask

   task automatic test_reset();
      #1 reset = 1'b1;
      #2;
      n_cmp++;
      if ({out_valid, carry_out, overflow, out} !== 19'd0) begin
         n_bad++;
         $display("FAIL reset_state: got valid=%b cout=%b ovf=%b out=%h, want all zero",
                  out_valid, carry_out, overflow, out);
      end
      repeat (2) @(posedge clk);
      #3 reset = 1'b0;
      pipe_q.delete();
   endtask

   task automatic test_directed();
      logic [15:0] da [8];
      logic [15:0] db [8];
      logic        dc [8];
      logic [15:0] dexp [8];
      logic        dco [8];
      logic        dov [8];
      logic        ev, ec, eov;
      logic [15:0] eo;
      da  = '{16'hFFFF, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0FFF, 16'h8000};
      db  = '{16'hFFFF, 16'h000B, 16'h0001, 16'h0000, 16'h0001, 16'hFFFF, 16'h00F1, 16'h8000};
      dc  = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b1,     1'b0};
      dco = '{1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1,     1'b0,     1'b1};
      dov = '{1'b0,     1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b0,     1'b1};
`ifdef ADDER_SATURATE_EN
      dexp = '{16'hFFFE, 16'h000A, 16'h0100, 16'h0000, 16'h7FFF, 16'h8000, 16'h10F1, 16'h8000};
`else
      dexp = '{16'hFFFE, 16'h000A, 16'h0100, 16'h0000, 16'h8000, 16'h7FFF, 16'h10F1, 16'h0000};
`endif
      for (int i = 0; i < 8; i++) begin
         step(1'b1, da[i], db[i], dc[i], ev, eo, ec, eov);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL directed_latency[%0d]: out_valid=%b one edge after sampling, want 0", i, out_valid);
         end
         step(1'b0, 16'hxxxx, 16'hxxxx, 1'bx, ev, eo, ec, eov);
         n_cmp++;
         if ({out_valid, carry_out, overflow, out} !== {1'b1, dco[i], dov[i], dexp[i]}) begin
            n_bad++;
            $display("FAIL directed[%0d] %h+%h+%b: got valid=%b cout=%b ovf=%b out=%h, want valid=1 cout=%b ovf=%b out=%h",
                     i, da[i], db[i], dc[i], out_valid, carry_out, overflow, out, dco[i], dov[i], dexp[i]);
         end
      end
   endtask

   task automatic test_back_to_back(input int n);
      logic        ev, ec, eov;
      logic [15:0] eo;
      for (int i = 0; i < n + STAGES; i++) begin
         if (i < n) step(1'b1, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), ev, eo, ec, eov);
         else       step(1'b0, 16'hxxxx, 16'hxxxx, 1'bx, ev, eo, ec, eov);
         n_cmp++;
         if (out_valid !== ev) begin
            n_bad++;
            $display("FAIL b2b_valid[%0d]: got %b, want %b", i, out_valid, ev);
         end else if (ev) begin
            n_cmp++;
            if ({carry_out, overflow, out} !== {ec, eov, eo}) begin
               n_bad++;
               $display("FAIL b2b_data[%0d]: got cout=%b ovf=%b out=%h, want cout=%b ovf=%b out=%h",
                        i, carry_out, overflow, out, ec, eov, eo);
            end
         end
      end
   endtask

   task automatic test_stream();
      logic        ev, ec, eov;
      logic [15:0] eo;
      int          sent = 0;
      int          cyc  = 0;
      while (sent < 16 || pipe_q.size() > 0) begin
         if (sent < 16 && $urandom_range(0, 2) != 0) begin
            step(1'b1, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)), ev, eo, ec, eov);
            sent++;
         end else begin
            step(1'b0, 16'hxxxx, 16'hxxxx, 1'bx, ev, eo, ec, eov);
            if (sent >= 16) pipe_q.delete();
         end
         n_cmp++;
         if (out_valid !== ev) begin
            n_bad++;
            $display("FAIL stream_valid[%0d]: got %b, want %b", cyc, out_valid, ev);
         end else if (ev) begin
            n_cmp++;
            if ({carry_out, overflow, out} !== {ec, eov, eo}) begin
               n_bad++;
               $display("FAIL stream_data[%0d]: got cout=%b ovf=%b out=%h, want cout=%b ovf=%b out=%h",
                        cyc, carry_out, overflow, out, ec, eov, eo);
            end
         end
         cyc++;
         if (cyc > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: %0d pairs sent after %0d cycles, want 16", sent, cyc);
            break;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic        ev, ec, eov;
      logic [15:0] eo;
      step(1'b1, 16'h1234, 16'h4321, 1'b0, ev, eo, ec, eov);
      step(1'b1, 16'h7FFF, 16'h7FFF, 1'b1, ev, eo, ec, eov);
      n_cmp++;
      if (out_valid !== 1'b1 || out !== 16'h5555) begin
         n_bad++;
         $display("FAIL mid_pre_reset: got valid=%b out=%h, want valid=1 out=5555", out_valid, out);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({out_valid, carry_out, overflow, out} !== 19'd0) begin
         n_bad++;
         $display("FAIL mid_reset_async: got valid=%b cout=%b ovf=%b out=%h, want all zero",
                  out_valid, carry_out, overflow, out);
      end
      in_valid = 1'b1;
      input1   = 16'($urandom);
      input2   = 16'($urandom);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({out_valid, carry_out, overflow, out} !== 19'd0) begin
         n_bad++;
         $display("FAIL mid_reset_held: got valid=%b out=%h, want 0/0000", out_valid, out);
      end
      reset = 1'b0;
      pipe_q.delete();
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 16'hxxxx, 16'hxxxx, 1'bx, ev, eo, ec, eov);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_stale[%0d]: out_valid=%b after release, want 0", i, out_valid);
         end
      end
   endtask

   initial begin
      corner = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
      test_reset();
      test_directed();
      test_back_to_back(10);
      test_stream();
      test_reset_mid();
      test_back_to_back(6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/n_bit_adder_pipe.md
Name: n_bit_adder_pipe

Overview:
- Pipelined two's-complement N-bit adder: the leaf add element of the feature adder tree (pairwise sums of sign-extended features, then accumulation with the running dimension value).
- Carry chain split into STAGES equal chunks, one chunk per register stage.
- Full throughput (one new operand pair per cycle), fixed latency, valid tag carried alongside the data.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 2.
- STAGES, 2, number of pipeline stages (carry chunks); 1 <= STAGES <= WIDTH and WIDTH % STAGES == 0, otherwise elaboration error. CHUNK = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous reset, active-high.
- in_valid  input  1  qualifies input1/input2/carry_in this cycle.
- input1  input  WIDTH  operand A, two's complement.
- input2  input  WIDTH  operand B, two's complement.
- carry_in  input  1  carry into bit 0.
- out  output  WIDTH  registered sum.
- out_valid  output  1  out/carry_out/overflow valid.
- carry_out  output  1  unsigned carry out of the MSB.
- overflow  output  1  signed overflow flag.

Behaviour:
- Reset (async assert, sync release): every pipeline register cleared; out=0, out_valid=0, carry_out=0, overflow=0. Data in flight is discarded.
- Stage k (0..STAGES-1) adds chunk k of A and B plus the carry registered from stage k-1 (stage 0 uses carry_in). It registers:
  - its CHUNK-bit partial sum;
  - its carry;
  - the unconsumed upper chunks of A/B (input skew);
  - the lower result chunks already computed (output deskew).
- Latency is exactly STAGES cycles: a pair sampled at edge t appears on out at edge t+STAGES-1, i.e. visible after STAGES rising edges including the sampling edge.
- out_valid is in_valid delayed by STAGES.
- Throughput is 1 per cycle. There is no stall or backpressure.
- Data registers update every cycle regardless of in_valid. Content of out while out_valid=0 is don't-care for checking.
- Arithmetic: {carry_out,out} = A + B + carry_in, computed modulo 2^(WIDTH+1).
- overflow = (A[MSB]==B[MSB]) && (sum[MSB]!=A[MSB]), where sum is the raw wrapped sum.
- Carry propagates across chunk boundaries; the result must be bit-identical to a single-cycle WIDTH-bit add.
- STAGES=1: one combinational add followed by one output register.
- X on inputs with in_valid=0 must not reach out_valid.

Optional Feature:
- Macro ADDER_SATURATE_EN.
- Defined: when overflow=1, out is clamped. Positive overflow (A,B non-negative) gives 2^(WIDTH-1)-1; negative overflow gives -2^(WIDTH-1). The clamp is applied in the final stage with no extra latency. carry_out and overflow still report the raw result.
- Undefined: out wraps modulo 2^WIDTH; no clamp logic is present.

Test Plan (WIDTH=16, STAGES=2):
- Reset mid-stream: assert reset asynchronously between edges with two pairs in flight -> out=0, out_valid=0 immediately; no stale result appears after release.
- Sign-extended operands: A=0xFFFF (-1), B=0xFFFF, cin=0 -> out=0xFFFE, carry_out=1, overflow=0, out_valid high 2 cycles after in_valid.
- Mixed signs: A=0xFFFF, B=0x000B -> out=0x000A, carry_out=1, overflow=0.
- Cross-chunk carry: A=0x00FF, B=0x0001, cin=0 -> out=0x0100. Also A=0xFFFF, B=0, cin=1 -> out=0x0000, carry_out=1.
- Signed overflow: A=0x7FFF, B=0x0001 -> overflow=1; out=0x8000 without the macro, 0x7FFF with ADDER_SATURATE_EN. A=0x8000, B=0xFFFF -> overflow=1; out=0x7FFF without the macro, 0x8000 with it.
- Streaming: 16 back-to-back random pairs with in_valid gaps -> each out matches (A+B+cin) mod 2^16 in order. out_valid pattern equals in_valid delayed by 2.
